// File: rtl/data_memory_pkg.sv
// data_memory_pkg: load/store length encodings and data memory defaults shared with the datapath
//   len_t            : 2-bit access size (none/byte/half/word)
//   DMEM_DEPTH_BYTES : default storage size in bytes
//   DMEM_BASE_ADDR   : default first byte address of the window
//   lane_en()        : 1 when byte lane (0..3) takes part in an access of the given size
package data_memory_pkg;
  typedef enum logic [1:0] {
    LEN_NONE = 2'b00,
    LEN_BYTE = 2'b01,
    LEN_HALF = 2'b10,
    LEN_WORD = 2'b11
  } len_t;
  localparam int unsigned DMEM_DEPTH_BYTES = 4096;
  localparam logic [31:0] DMEM_BASE_ADDR = 32'h0000_0000;
  function automatic logic lane_en(input logic [1:0] len, input logic [1:0] lane);
    return len == LEN_WORD || (len == LEN_HALF && !lane[1]) || (len == LEN_BYTE && lane == 2'd0);
  endfunction
endpackage

// File: rtl/dmem_load_format.sv
// dmem_load_format: turns four raw little-endian bytes into a sized, sign/zero-extended load result
//   raw      in  4 bytes read at address+0..address+3 (byte 0 in raw[0])
//   len      in  load size (LEN_NONE gives 0)
//   sign_ext in  1 = sign-extend byte/half loads
//   data     out formatted 32-bit load value
module dmem_load_format
  import data_memory_pkg::*;
(
  input  logic [3:0][7:0] raw,
  input  logic [1:0]      len,
  input  logic            sign_ext,
  output logic [31:0]     data
);
  always_comb
    data = len == LEN_WORD ? raw :
           len == LEN_HALF ? {{16{sign_ext & raw[1][7]}}, raw[1], raw[0]} :
           len == LEN_BYTE ? {{24{sign_ext & raw[0][7]}}, raw[0]} : 32'd0;
endmodule

// File: rtl/data_memory.sv
// data_memory: byte-addressable little-endian data memory, sync byte/half/word stores, combinational loads
//   SYS_clk            in  clock, stores on rising edge
//   SYS_reset          in  sync active-high reset; forces MEM_read_data to 0 and blocks stores
//   MEM_write_length   in  store size (len_t), 00 = no store
//   MEM_write_data     in  store data, low bytes used for narrow stores
//   MEM_write_address  in  store byte address
//   MEM_read_length    in  load size (len_t), 00 = result 0
//   MEM_read_signed    in  sign-extend byte/half loads
//   MEM_read_address   in  load byte address
//   MEM_read_data      out load result
// Define DMEM_RESET_CLEAR_EN to zero every byte on each edge with SYS_reset high;
// otherwise contents start at zero and survive reset.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = DMEM_DEPTH_BYTES,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic [1:0]  MEM_write_length,
  input  logic [1:0]  MEM_read_length,
  input  logic        MEM_read_signed,
  input  logic [31:0] MEM_write_data,
  input  logic [31:0] MEM_write_address,
  input  logic [31:0] MEM_read_address,
  output logic [31:0] MEM_read_data
);
  localparam int IW = $clog2(DEPTH_BYTES);
  localparam logic [32:0] LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI = {1'b0, BASE_ADDR} + 33'(DEPTH_BYTES);
  logic [7:0] mem [DEPTH_BYTES] = '{default: 8'h00};
  logic [3:0][7:0] rd;
  logic [3:0][IW-1:0] wi;
  logic [3:0] we;
  logic [31:0] fmt;
  // Each lane decodes its own byte address with a 33-bit sum so that carrying
  // past 32'hFFFF_FFFF lands above the window instead of wrapping into it.
  // BASE_ADDR is DEPTH-aligned, so the low IW bits of the address are the index.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [32:0] rs, ws;
    assign rs = {1'b0, MEM_read_address} + 33'(i);
    assign ws = {1'b0, MEM_write_address} + 33'(i);
    assign rd[i] = (rs >= LO && rs < HI) ? mem[rs[IW-1:0]] : 8'h00;
    assign wi[i] = ws[IW-1:0];
    assign we[i] = ws >= LO && ws < HI && !SYS_reset && lane_en(MEM_write_length, 2'(i));
  end
  always_ff @(posedge SYS_clk) begin
`ifdef DMEM_RESET_CLEAR_EN
    if (SYS_reset)
      for (int unsigned k = 0; k < DEPTH_BYTES; k++) mem[IW'(k)] <= 8'h00;
`endif
    for (int n = 0; n < 4; n++)
      if (we[n]) mem[wi[n]] <= MEM_write_data[8*n +: 8];
  end
  dmem_load_format u_fmt (
    .raw      (rd),
    .len      (MEM_read_length),
    .sign_ext (MEM_read_signed),
    .data     (fmt)
  );
  assign MEM_read_data = SYS_reset ? 32'd0 : fmt;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: scoreboard bench for data_memory against a byte-level reference model
module tb_data_memory;
  import data_memory_pkg::*;
  localparam int unsigned DEPTH = 4096;
  localparam logic [31:0] B = 32'hFFFF_F000;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] wlen, rlen;
  logic rsign;
  logic [31:0] wdata, waddr, raddr, rdata;
  always #5 clk = ~clk;
  data_memory #(.DEPTH_BYTES(DEPTH), .BASE_ADDR(B)) dut (
    .SYS_clk           (clk),
    .SYS_reset         (rst),
    .MEM_write_length  (wlen),
    .MEM_read_length   (rlen),
    .MEM_read_signed   (rsign),
    .MEM_write_data    (wdata),
    .MEM_write_address (waddr),
    .MEM_read_address  (raddr),
    .MEM_read_data     (rdata)
  );
  typedef struct {
    string       tag;
    logic [31:0] exp;
  } item_t;
  item_t q[$];
  item_t it;
  logic [7:0] mdl [int];
  int total = 0;
  int bad = 0;
  function automatic int nbytes(input logic [1:0] len);
    return len == 2'd1 ? 1 : len == 2'd2 ? 2 : len == 2'd3 ? 4 : 0;
  endfunction
  function automatic bit in_win(input logic [63:0] p);
    return p >= 64'(B) && p < 64'(B) + 64'(DEPTH);
  endfunction
  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] len, input logic sgn);
    logic [63:0] v, p;
    int n, idx;
    v = 0;
    n = nbytes(len);
    for (int k = 0; k < n; k++) begin
      p = 64'(a) + 64'(k);
      idx = int'(p - 64'(B));
      if (in_win(p) && mdl.exists(idx)) v = v + (64'(mdl[idx]) << (8 * k));
    end
    if (sgn && n > 0 && n < 4 && v >= (64'd1 << (8 * n - 1)))
      v = v + 64'h1_0000_0000 - (64'd1 << (8 * n));
    return v[31:0];
  endfunction
  task automatic model_write(input logic [31:0] a, input logic [1:0] len, input logic [31:0] d);
    logic [63:0] p;
    for (int k = 0; k < nbytes(len); k++) begin
      p = 64'(a) + 64'(k);
      if (in_win(p)) mdl[int'(p - 64'(B))] = d[8*k +: 8];
    end
  endtask
  task automatic cycle(input logic r, input logic [1:0] wl, input logic [31:0] wd, input logic [31:0] wa,
                       input logic [1:0] rl, input logic rs, input logic [31:0] ra, input string tag);
    item_t e;
    rst = r; wlen = wl; wdata = wd; waddr = wa; rlen = rl; rsign = rs; raddr = ra;
    e.tag = tag;
    e.exp = r ? 32'd0 : model_read(ra, rl, rs);
    q.push_back(e);
    @(posedge clk);
    if (r) begin
`ifdef DMEM_RESET_CLEAR_EN
      mdl.delete();
`endif
    end else if (wl != 2'd0) model_write(wa, wl, wd);
    #1;
  endtask
  task automatic rd_only(input logic [1:0] rl, input logic rs, input logic [31:0] ra, input string tag);
    cycle(1'b0, LEN_NONE, 32'd0, 32'd0, rl, rs, ra, tag);
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      it = q.pop_front();
      total++;
      if (rdata !== it.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h (raddr=%h rlen=%0d signed=%0d)", it.tag, rdata, it.exp, raddr, rlen, rsign);
      end
    end
  end
  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0: return B + $urandom_range(0, 63);
      1: return B + DEPTH - $urandom_range(1, 6);
      2: return B - $urandom_range(1, 4);
      default: return B + DEPTH + $urandom_range(0, 3);
    endcase
  endfunction
  initial begin
    int w;
    rst = 1'b1; wlen = 0; rlen = 0; rsign = 0; wdata = 0; waddr = 0; raddr = 0;
    @(posedge clk);
    #1;
    rlen = LEN_WORD; rsign = 1'b1; raddr = B + 32'h4;
    #1;
    total++;
    if (rdata !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: got %h want 00000000", rdata);
    end
    cycle(1'b1, LEN_NONE, 32'd0, 32'd0, LEN_WORD, 1'b0, B, "reset_read");
    cycle(1'b1, LEN_NONE, 32'd0, 32'd0, LEN_BYTE, 1'b1, B + 1, "reset_read2");
    cycle(1'b0, LEN_WORD, 32'hDEADBEEF, B + 32'h10, LEN_NONE, 1'b0, B + 32'h10, "rlen_none");
    rd_only(LEN_WORD, 1'b0, B + 32'h10, "word_10");
    for (int k = 0; k < 4; k++) rd_only(LEN_BYTE, 1'b0, B + 32'h10 + 32'(k), "byte_1x");
    cycle(1'b0, LEN_BYTE, 32'h12345680, B + 32'h20, LEN_NONE, 1'b0, 32'd0, "store_byte");
    rd_only(LEN_BYTE, 1'b1, B + 32'h20, "byte_signed");
    rd_only(LEN_BYTE, 1'b0, B + 32'h20, "byte_unsigned");
    for (int k = 1; k < 4; k++) rd_only(LEN_BYTE, 1'b0, B + 32'h20 + 32'(k), "byte_untouched");
    cycle(1'b0, LEN_HALF, 32'h00008001, B + 32'h31, LEN_NONE, 1'b0, 32'd0, "store_half");
    rd_only(LEN_HALF, 1'b1, B + 32'h31, "half_misaligned");
    rd_only(LEN_WORD, 1'b0, B + 32'h30, "word_30");
    cycle(1'b0, LEN_WORD, 32'hAABBCCDD, B + DEPTH - 2, LEN_NONE, 1'b0, 32'd0, "store_edge");
    rd_only(LEN_BYTE, 1'b0, B + DEPTH - 2, "edge_byte0");
    rd_only(LEN_BYTE, 1'b0, B + DEPTH - 1, "edge_byte1");
    rd_only(LEN_WORD, 1'b0, B + DEPTH - 2, "edge_word");
    rd_only(LEN_WORD, 1'b0, B + DEPTH, "past_end");
    rd_only(LEN_WORD, 1'b0, B - 1, "below_base");
    cycle(1'b0, LEN_WORD, 32'h11111111, B + 32'h40, LEN_WORD, 1'b0, B + 32'h40, "same_cycle_pre");
    rd_only(LEN_WORD, 1'b0, B + 32'h40, "same_cycle_post");
    rd_only(LEN_NONE, 1'b1, B + 32'h40, "rlen_none2");
    cycle(1'b0, LEN_WORD, 32'hCAFEBABE, B + 32'h50, LEN_NONE, 1'b0, 32'd0, "store_50");
    cycle(1'b1, LEN_WORD, 32'h12345678, B + 32'h50, LEN_WORD, 1'b0, B + 32'h50, "reset_store");
    rd_only(LEN_WORD, 1'b0, B + 32'h50, "after_reset");
    rd_only(LEN_WORD, 1'b0, B + 32'h10, "after_reset_10");
    for (int n = 0; n < 400; n++)
      cycle($urandom_range(0, 39) == 0, 2'($urandom_range(0, 3)), $urandom, rand_addr(),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rand_addr(), "random");
    rst = 1'b0; wlen = LEN_NONE; rlen = LEN_NONE;
    w = 0;
    while (q.size() > 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL expired_wait: %0d expected reads never checked", q.size());
    end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
